// File: rtl/tt_um_andreaklcortez_prbs31_chk_if.sv
// Pin bundle of the PRBS31 checker: enable plus the Tiny Tapeout style
// dedicated and bidirectional I/O bytes.
interface tt_um_andreaklcortez_prbs31_chk_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_andreaklcortez_prbs31_chk.sv
// PRBS31 (x^31+x^28+1) bit-error checker: self-synchronising seed/hunt,
// free-running reference once locked, windowed loss-of-lock, 16-bit error count.
module tt_um_andreaklcortez_prbs31_chk #(
   parameter int LOCK_COUNT = 32,
   parameter int WIN_LEN    = 64,
   parameter int UNLOCK_ERR = 8
) (
   input logic                              clk,
   input logic                              rst_n,
   tt_um_andreaklcortez_prbs31_chk_if.slave bus
);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam int WW = $clog2(WIN_LEN + 1);
   localparam int EW = $clog2(UNLOCK_ERR + 1);

   // LOCKED is the only encoding with bit 1 set, so locked is a flop output.
   typedef enum logic [1:0] {SEED = 2'b00, HUNT = 2'b01, LOCKED = 2'b10} state_t;

   state_t        state, state_nxt;
   logic [30:0]   s, s_nxt;
   logic [4:0]    fill, fill_nxt;
   logic [MW-1:0] match, match_nxt;
   logic [WW-1:0] win_cnt, win_cnt_nxt;
   logic [EW-1:0] win_err, win_err_nxt;
   logic [15:0]   err_cnt, err_cnt_nxt;
   logic          err_pulse, err_sat, locked;

   logic valid, clr, r, p, err;
   logic unused_pins;

   assign valid       = bus.ui_in[1] & bus.ena;
   assign clr         = bus.ui_in[2];
   assign r           = bus.ui_in[0] ^ bus.ui_in[3];
   assign p           = s[30] ^ s[27];
   assign err         = valid && (state == LOCKED) && (r != p);
   assign unused_pins = &{1'b0, bus.uio_in, bus.ui_in[7:5]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= SEED;
         s         <= '0;
         fill      <= '0;
         match     <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         err_cnt   <= '0;
         err_pulse <= 1'b0;
         err_sat   <= 1'b0;
      end else begin
         state     <= state_nxt;
         s         <= s_nxt;
         fill      <= fill_nxt;
         match     <= match_nxt;
         win_cnt   <= win_cnt_nxt;
         win_err   <= win_err_nxt;
         err_cnt   <= err_cnt_nxt;
         err_pulse <= err;
         err_sat   <= (err_cnt_nxt == 16'hFFFF);
      end
   end

   always_comb begin
      state_nxt   = state;
      s_nxt       = s;
      fill_nxt    = fill;
      match_nxt   = match;
      win_cnt_nxt = win_cnt;
      win_err_nxt = win_err;
      if (valid) begin
         case (state)
            SEED: begin
               s_nxt = {s[29:0], r};
               if (fill == 5'd30) begin
                  fill_nxt  = '0;
                  match_nxt = '0;
                  state_nxt = HUNT;
               end else begin
                  fill_nxt = fill + 5'd1;
               end
            end
            HUNT: begin
               s_nxt = {s[29:0], r};
               // An all-zero register predicts zeros forever; never count that as a match.
               if ((s == '0) || (r != p)) begin
                  match_nxt = '0;
               end else if (match == MW'(LOCK_COUNT - 1)) begin
                  match_nxt   = '0;
                  win_cnt_nxt = '0;
                  win_err_nxt = '0;
                  state_nxt   = LOCKED;
               end else begin
                  match_nxt = match + MW'(1);
               end
            end
            LOCKED: begin
               s_nxt = {s[29:0], p};
               // Threshold is tested before the window boundary clears the tally.
               if (err && (win_err == EW'(UNLOCK_ERR - 1))) begin
                  state_nxt   = SEED;
                  fill_nxt    = '0;
                  match_nxt   = '0;
                  win_cnt_nxt = '0;
                  win_err_nxt = '0;
               end else if (win_cnt == WW'(WIN_LEN - 1)) begin
                  win_cnt_nxt = '0;
                  win_err_nxt = '0;
               end else begin
                  win_cnt_nxt = win_cnt + WW'(1);
                  win_err_nxt = win_err + EW'(err);
               end
            end
            default: state_nxt = SEED;
         endcase
      end

      err_cnt_nxt = err_cnt;
      if (clr) begin
         err_cnt_nxt = '0;
      end else if (err && (err_cnt != 16'hFFFF)) begin
         err_cnt_nxt = err_cnt + 16'd1;
      end
   end

   always_comb begin
      locked      = state[1];
      bus.uo_out  = bus.ui_in[4] ? err_cnt[15:8] : err_cnt[7:0];
      bus.uio_out = {5'b0, err_sat, err_pulse, locked};
      bus.uio_oe  = 8'b0000_0111;
   end
endmodule

// File: tb/tb_tt_um_andreaklcortez_prbs31_chk.sv
// Directed bench for the PRBS31 checker: a default-parameter instance for lock,
// error and loss-of-lock behaviour, and a never-unlocking instance for saturation.
module tb_tt_um_andreaklcortez_prbs31_chk;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, ena_a, bit_a, vld_a, clr_a, inv_a, bsel_a;
   logic rst_b, ena_b, bit_b, vld_b, clr_b, inv_b, bsel_b;

   tt_um_andreaklcortez_prbs31_chk_if bus_a ();
   tt_um_andreaklcortez_prbs31_chk_if bus_b ();

   assign bus_a.ena    = ena_a;
   assign bus_a.ui_in  = {3'b000, bsel_a, inv_a, clr_a, vld_a, bit_a};
   assign bus_a.uio_in = 8'h00;
   assign bus_b.ena    = ena_b;
   assign bus_b.ui_in  = {3'b000, bsel_b, inv_b, clr_b, vld_b, bit_b};
   assign bus_b.uio_in = 8'h00;

   tt_um_andreaklcortez_prbs31_chk u_dut (
      .clk   (clk),
      .rst_n (rst_a),
      .bus   (bus_a)
   );

   tt_um_andreaklcortez_prbs31_chk #(.UNLOCK_ERR(65)) u_sat (
      .clk   (clk),
      .rst_n (rst_b),
      .bus   (bus_b)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          since_lock = 0;
   int          pulses_a = 0;
   logic        ever_a = 1'b0;
   logic [30:0] g;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference PRBS31 generator, same polynomial as the checker.
   task automatic gen(output logic b);
      b = g[30] ^ g[27];
      g = {g[29:0], b};
   endtask

   task automatic step_a(input logic b, input logic v);
      bit_a = b;
      vld_a = v;
      @(posedge clk);
      #1;
      if (v && ena_a && rst_a) since_lock++;
      if (bus_a.uio_out[1] === 1'b1) pulses_a++;
      if (bus_a.uio_out[0] === 1'b1) ever_a = 1'b1;
   endtask

   task automatic send_a(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         gen(b);
         step_a(b, 1'b1);
      end
   endtask

   task automatic flip_a();
      logic b;
      gen(b);
      step_a(~b, 1'b1);
   endtask

   task automatic rd_a(output logic [15:0] v);
      bsel_a = 1'b1;
      #1 v[15:8] = bus_a.uo_out;
      bsel_a = 1'b0;
      #1 v[7:0] = bus_a.uo_out;
   endtask

   task automatic step_b(input logic b, input logic v);
      bit_b = b;
      vld_b = v;
      @(posedge clk);
      #1;
   endtask

   task automatic flip_b();
      logic b;
      gen(b);
      step_b(~b, 1'b1);
   endtask

   task automatic rd_b(output logic [15:0] v);
      bsel_b = 1'b1;
      #1 v[15:8] = bus_b.uo_out;
      bsel_b = 1'b0;
      #1 v[7:0] = bus_b.uo_out;
   endtask

   initial begin
      logic        b;
      logic [15:0] v;
      rst_a = 1'b0; ena_a = 1'b1; bit_a = 1'b0; vld_a = 1'b0;
      clr_a = 1'b0; inv_a = 1'b0; bsel_a = 1'b0;
      rst_b = 1'b0; ena_b = 1'b1; bit_b = 1'b0; vld_b = 1'b0;
      clr_b = 1'b0; inv_b = 1'b0; bsel_b = 1'b0;

      // Reset with live inputs applied
      step_a(1'b1, 1'b1);
      step_a(1'b1, 1'b1);
      check("rst_uo_out", {8'h00, bus_a.uo_out}, 16'h0000);
      check("rst_uio_out", {8'h00, bus_a.uio_out}, 16'h0000);
      check("rst_uio_oe", {8'h00, bus_a.uio_oe}, 16'h0007);

      // Clean lock: locked exactly after bit 63
      rst_a = 1'b1;
      g = 31'h7FFFFFFF;
      send_a(62);
      check("lock_bit62", {15'd0, bus_a.uio_out[0]}, 16'd0);
      send_a(1);
      since_lock = 0;
      check("lock_bit63", {15'd0, bus_a.uio_out[0]}, 16'd1);
      pulses_a = 0;
      send_a(1000);
      rd_a(v);
      check("clean_err_cnt", v, 16'd0);
      check("clean_locked", {15'd0, bus_a.uio_out[0]}, 16'd1);
      check("clean_pulses", 16'(pulses_a), 16'd0);

      // Gated cycles (ena low, then rx_valid low) carry garbage and change nothing
      ena_a = 1'b0;
      for (int i = 0; i < 10; i++) step_a(i[0], 1'b1);
      ena_a = 1'b1;
      for (int i = 0; i < 10; i++) step_a(~i[0], 1'b0);
      send_a(100);
      rd_a(v);
      check("gated_err_cnt", v, 16'd0);
      check("gated_pulses", 16'(pulses_a), 16'd0);
      check("gated_locked", {15'd0, bus_a.uio_out[0]}, 16'd1);

      // Five isolated single-bit errors
      for (int k = 0; k < 5; k++) begin
         send_a(99);
         flip_a();
         check("pulse_high", {15'd0, bus_a.uio_out[1]}, 16'd1);
         send_a(1);
         check("pulse_low", {15'd0, bus_a.uio_out[1]}, 16'd0);
      end
      rd_a(v);
      check("single_err_cnt", v, 16'd5);
      check("single_pulses", 16'(pulses_a), 16'd5);
      check("single_locked", {15'd0, bus_a.uio_out[0]}, 16'd1);

      // Clear on a non-valid cycle
      clr_a = 1'b1;
      step_a(1'b0, 1'b0);
      clr_a = 1'b0;
      rd_a(v);
      check("clr_err_cnt", v, 16'd0);
      check("clr_locked", {15'd0, bus_a.uio_out[0]}, 16'd1);

      // Eight errors inside one window -> loss of lock, then relock
      while (since_lock % 64 != 0) send_a(1);
      for (int i = 0; i < 7; i++) flip_a();
      check("burst_7_locked", {15'd0, bus_a.uio_out[0]}, 16'd1);
      flip_a();
      check("burst_8_unlocked", {15'd0, bus_a.uio_out[0]}, 16'd0);
      rd_a(v);
      check("burst_err_cnt", v, 16'd8);
      send_a(62);
      check("relock_bit62", {15'd0, bus_a.uio_out[0]}, 16'd0);
      send_a(1);
      since_lock = 0;
      check("relock_bit63", {15'd0, bus_a.uio_out[0]}, 16'd1);
      rd_a(v);
      check("relock_err_kept", v, 16'd8);

      // Seven errors ending a window plus one opening the next stay locked
      while (since_lock % 64 != 57) send_a(1);
      for (int i = 0; i < 8; i++) flip_a();
      check("split_locked", {15'd0, bus_a.uio_out[0]}, 16'd1);
      rd_a(v);
      check("split_err_cnt", v, 16'd16);

      // Eighth error on the final bit of a window still unlocks
      send_a(64);
      while (since_lock % 64 != 56) send_a(1);
      for (int i = 0; i < 7; i++) flip_a();
      check("edge_7_locked", {15'd0, bus_a.uio_out[0]}, 16'd1);
      flip_a();
      check("edge_8_unlocked", {15'd0, bus_a.uio_out[0]}, 16'd0);
      rd_a(v);
      check("edge_err_cnt", v, 16'd24);

      // All-zero input never locks
      rst_a = 1'b0;
      step_a(1'b0, 1'b0);
      rst_a = 1'b1;
      ever_a = 1'b0;
      for (int i = 0; i < 500; i++) step_a(1'b0, 1'b1);
      check("zero_never_locked", {15'd0, ever_a}, 16'd0);
      rd_a(v);
      check("zero_err_cnt", v, 16'd0);

      // Complemented stream with inv=1 locks on schedule
      rst_a = 1'b0;
      step_a(1'b0, 1'b0);
      rst_a = 1'b1;
      inv_a = 1'b1;
      g = 31'h7FFFFFFF;
      for (int i = 0; i < 62; i++) begin gen(b); step_a(~b, 1'b1); end
      check("inv_bit62", {15'd0, bus_a.uio_out[0]}, 16'd0);
      gen(b);
      step_a(~b, 1'b1);
      check("inv_bit63", {15'd0, bus_a.uio_out[0]}, 16'd1);

      // Same complemented stream with inv=0 never locks
      rst_a = 1'b0;
      step_a(1'b0, 1'b0);
      rst_a = 1'b1;
      inv_a = 1'b0;
      ever_a = 1'b0;
      g = 31'h7FFFFFFF;
      for (int i = 0; i < 300; i++) begin gen(b); step_a(~b, 1'b1); end
      check("noinv_never_locked", {15'd0, ever_a}, 16'd0);

      // Saturation on the instance that cannot lose lock
      step_b(1'b0, 1'b0);
      rst_b = 1'b1;
      g = 31'h7FFFFFFF;
      for (int i = 0; i < 63; i++) begin gen(b); step_b(b, 1'b1); end
      check("sat_locked", {15'd0, bus_b.uio_out[0]}, 16'd1);
      repeat (65534) flip_b();
      rd_b(v);
      check("sat_fffe_cnt", v, 16'hFFFE);
      check("sat_fffe_flag", {15'd0, bus_b.uio_out[2]}, 16'd0);
      flip_b();
      bsel_b = 1'b0;
      #1 check("sat_uo_low", {8'h00, bus_b.uo_out}, 16'h00FF);
      bsel_b = 1'b1;
      #1 check("sat_uo_high", {8'h00, bus_b.uo_out}, 16'h00FF);
      bsel_b = 1'b0;
      check("sat_flag", {15'd0, bus_b.uio_out[2]}, 16'd1);
      flip_b();
      rd_b(v);
      check("sat_hold_cnt", v, 16'hFFFF);
      check("sat_hold_pulse", {15'd0, bus_b.uio_out[1]}, 16'd1);

      // Clear coinciding with an error: clear wins, pulse still fires
      clr_b = 1'b1;
      flip_b();
      clr_b = 1'b0;
      rd_b(v);
      check("clrerr_cnt", v, 16'd0);
      check("clrerr_pulse", {15'd0, bus_b.uio_out[1]}, 16'd1);
      check("clrerr_flag", {15'd0, bus_b.uio_out[2]}, 16'd0);
      check("clrerr_locked", {15'd0, bus_b.uio_out[0]}, 16'd1);

      // Reset mid-lock, with clear and an error also present
      clr_b = 1'b1;
      rst_b = 1'b0;
      flip_b();
      clr_b = 1'b0;
      rd_b(v);
      check("midrst_cnt", v, 16'd0);
      check("midrst_uio_out", {8'h00, bus_b.uio_out}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
